// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_pkg
//  Description : Shared opcodes, FSM state type and ALU golden function for
//                the ALU command sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

    localparam logic [1:0] ALU_AND = 2'b00;
    localparam logic [1:0] ALU_OR  = 2'b01;
    localparam logic [1:0] ALU_SUB = 2'b10;
    localparam logic [1:0] ALU_ADD = 2'b11;

    // Widest operand the golden function handles; callers truncate the result.
    localparam int ALU_MAX_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } seq_state_e;

    // Sub and add are evaluated one bit wider than the operands, so that
    // truncating to DATA_W+1 bits yields the borrow-wrapped difference and
    // the carry-out sum respectively.
    function automatic logic [ALU_MAX_W:0] alu_expected(
        input logic [1:0]           code,
        input logic [ALU_MAX_W-1:0] a,
        input logic [ALU_MAX_W-1:0] b
    );
        logic [ALU_MAX_W:0] ea;
        logic [ALU_MAX_W:0] eb;
        logic [ALU_MAX_W:0] res;
        ea = {1'b0, a};
        eb = {1'b0, b};
        case (code)
            ALU_AND: res = ea & eb;
            ALU_OR:  res = ea | eb;
            ALU_SUB: res = ea - eb;
            default: res = ea + eb;
        endcase
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_cmd_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_cmd_sequencer_if
//  Description : Command and response valid/ready channels of the ALU
//                command sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_cmd_sequencer_if #(
    parameter int DATA_W = 4
);

    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_code;
    logic [DATA_W-1:0] cmd_a;
    logic [DATA_W-1:0] cmd_b;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W:0]   rsp_data;
    logic [1:0]        rsp_code;
    logic              rsp_err;

    // Control engine side
    modport master (
        output cmd_valid, cmd_code, cmd_a, cmd_b, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_code, rsp_err
    );

    // Sequencer side
    modport slave (
        input  cmd_valid, cmd_code, cmd_a, cmd_b, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_code, rsp_err
    );

endinterface
`default_nettype wire

// File: rtl/alu_cmd_sequencer_ref_model.sv
`default_nettype none
// ============================================================================
//  Module      : alu_ref_model
//  Description : Combinational golden model of the 2-bit-opcode ALU, used to
//                flag results that disagree with the device under test.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_ref_model
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  wire [1:0]        i_code,
    input  wire [DATA_W-1:0] i_a,
    input  wire [DATA_W-1:0] i_b,
    output logic [DATA_W:0]  o_expected
);

    assign o_expected = (DATA_W+1)'(alu_expected(i_code, ALU_MAX_W'(i_a), ALU_MAX_W'(i_b)));

endmodule
`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_cmd_sequencer
//  Description : Accepts one ALU command at a time, drives it into an external
//                combinational ALU, samples the result after WAIT_CYCLES
//                clocks and returns it on a valid/ready response channel.
//                Define ALU_SEQ_CHECK_EN to build the golden-model check that
//                drives rsp_err; otherwise rsp_err is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W      = 4,
    parameter int WAIT_CYCLES = 1,   // legal range 1..15
    parameter int CNT_W       = 8
) (
    input  wire                clk,
    input  wire                rst_n,
    alu_cmd_sequencer_if.slave bus,
    output logic [1:0]         alu_code,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    input  wire  [DATA_W:0]    alu_c,
    output logic               busy,
    output logic [CNT_W-1:0]   done_cnt
);

    localparam int                c_WAIT_W    = 4;
    localparam logic [c_WAIT_W-1:0] c_WAIT_LOAD = c_WAIT_W'(WAIT_CYCLES - 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_ONE  = c_WAIT_W'(1);
    localparam logic [CNT_W-1:0]    c_CNT_ONE   = CNT_W'(1);

    seq_state_e          state_q,    state_d;
    logic [c_WAIT_W-1:0] cnt_q,      cnt_d;
    logic [1:0]          alu_code_q, alu_code_d;
    logic [DATA_W-1:0]   alu_a_q,    alu_a_d;
    logic [DATA_W-1:0]   alu_b_q,    alu_b_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W:0]     rsp_data_q, rsp_data_d;
    logic [1:0]          rsp_code_q, rsp_code_d;
    logic [CNT_W-1:0]    done_cnt_q, done_cnt_d;

`ifdef ALU_SEQ_CHECK_EN
    logic                rsp_err_q,  rsp_err_d;
    logic [DATA_W:0]     w_expected;

    alu_ref_model #(
        .DATA_W (DATA_W)
    ) u_ref_model (
        .i_code     (alu_code_q),
        .i_a        (alu_a_q),
        .i_b        (alu_b_q),
        .o_expected (w_expected)
    );
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_code_d  = alu_code_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_code_d  = rsp_code_q;
        done_cnt_d  = done_cnt_q;
`ifdef ALU_SEQ_CHECK_EN
        rsp_err_d   = rsp_err_q;
`endif
        case (state_q)
            IDLE: begin
                // cmd_ready is high exactly in IDLE, so cmd_valid alone means a handshake
                if (bus.cmd_valid) begin
                    alu_code_d = bus.cmd_code;
                    alu_a_d    = bus.cmd_a;
                    alu_b_d    = bus.cmd_b;
                    cnt_d      = c_WAIT_LOAD;
                    state_d    = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - c_WAIT_ONE;
                end else begin
                    rsp_data_d  = alu_c;
                    rsp_code_d  = alu_code_q;
                    rsp_valid_d = 1'b1;
`ifdef ALU_SEQ_CHECK_EN
                    rsp_err_d   = (alu_c != w_expected);
`endif
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    done_cnt_d  = done_cnt_q + c_CNT_ONE;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            alu_code_q  <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_code_q  <= '0;
            done_cnt_q  <= '0;
`ifdef ALU_SEQ_CHECK_EN
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_code_q  <= alu_code_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_code_q  <= rsp_code_d;
            done_cnt_q  <= done_cnt_d;
`ifdef ALU_SEQ_CHECK_EN
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_code  = rsp_code_q;
`ifdef ALU_SEQ_CHECK_EN
    assign bus.rsp_err   = rsp_err_q;
`else
    assign bus.rsp_err   = 1'b0;
`endif

    assign alu_code = alu_code_q;
    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign busy     = (state_q != IDLE);
    assign done_cnt = done_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_cmd_sequencer
//  Description : Self-checking bench; DUT 0 uses default parameters, DUT 1
//                uses WAIT_CYCLES=3 and CNT_W=2. Honours ALU_SEQ_CHECK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_sequencer;

`ifdef ALU_SEQ_CHECK_EN
    localparam bit c_CHECK_EN = 1'b1;
`else
    localparam bit c_CHECK_EN = 1'b0;
`endif

    typedef struct {
        logic [1:0] code;
        logic [3:0] a;
        logic [3:0] b;
        logic [4:0] data;
        logic       err;     // only reported when the checker is built
        int         hold;    // cycles rsp_ready stays low after rsp_valid
        bit         tease;   // present a competing command during the hold
    } vec_t;

    typedef struct packed {
        logic [4:0] data;
        logic [1:0] code;
        logic       err;
    } exp_t;

    logic       clk;
    logic       rst_n_v     [2];
    logic       cmd_valid_v [2];
    logic [1:0] cmd_code_v  [2];
    logic [3:0] cmd_a_v     [2];
    logic [3:0] cmd_b_v     [2];
    logic       rsp_ready_v [2];
    logic       cmd_ready_v [2];
    logic       rsp_valid_v [2];
    logic [4:0] rsp_data_v  [2];
    logic [1:0] rsp_code_v  [2];
    logic       rsp_err_v   [2];
    logic [1:0] alu_code_v  [2];
    logic [3:0] alu_a_v     [2];
    logic [3:0] alu_b_v     [2];
    logic [4:0] alu_c_v     [2];
    logic       busy_v      [2];
    logic [7:0] done_a;
    logic [1:0] done_b;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb0 [$];
    exp_t sb1 [$];
    vec_t vecs_a [10];
    vec_t vecs_b [5];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    alu_cmd_sequencer_if #(.DATA_W(4)) bus_a ();
    alu_cmd_sequencer_if #(.DATA_W(4)) bus_b ();

    assign bus_a.cmd_valid = cmd_valid_v[0];
    assign bus_a.cmd_code  = cmd_code_v[0];
    assign bus_a.cmd_a     = cmd_a_v[0];
    assign bus_a.cmd_b     = cmd_b_v[0];
    assign bus_a.rsp_ready = rsp_ready_v[0];
    assign cmd_ready_v[0]  = bus_a.cmd_ready;
    assign rsp_valid_v[0]  = bus_a.rsp_valid;
    assign rsp_data_v[0]   = bus_a.rsp_data;
    assign rsp_code_v[0]   = bus_a.rsp_code;
    assign rsp_err_v[0]    = bus_a.rsp_err;

    assign bus_b.cmd_valid = cmd_valid_v[1];
    assign bus_b.cmd_code  = cmd_code_v[1];
    assign bus_b.cmd_a     = cmd_a_v[1];
    assign bus_b.cmd_b     = cmd_b_v[1];
    assign bus_b.rsp_ready = rsp_ready_v[1];
    assign cmd_ready_v[1]  = bus_b.cmd_ready;
    assign rsp_valid_v[1]  = bus_b.rsp_valid;
    assign rsp_data_v[1]   = bus_b.rsp_data;
    assign rsp_code_v[1]   = bus_b.rsp_code;
    assign rsp_err_v[1]    = bus_b.rsp_err;

    alu_cmd_sequencer #(.DATA_W(4), .WAIT_CYCLES(1), .CNT_W(8)) dut_a (
        .clk      (clk),
        .rst_n    (rst_n_v[0]),
        .bus      (bus_a.slave),
        .alu_code (alu_code_v[0]),
        .alu_a    (alu_a_v[0]),
        .alu_b    (alu_b_v[0]),
        .alu_c    (alu_c_v[0]),
        .busy     (busy_v[0]),
        .done_cnt (done_a)
    );

    alu_cmd_sequencer #(.DATA_W(4), .WAIT_CYCLES(3), .CNT_W(2)) dut_b (
        .clk      (clk),
        .rst_n    (rst_n_v[1]),
        .bus      (bus_b.slave),
        .alu_code (alu_code_v[1]),
        .alu_a    (alu_a_v[1]),
        .alu_b    (alu_b_v[1]),
        .alu_c    (alu_c_v[1]),
        .busy     (busy_v[1]),
        .done_cnt (done_b)
    );

    // ALU stand-in; deliberately wrong for OR 3,4 so the checker has something to flag
    function automatic logic [4:0] alu_stub(input logic [1:0] c, input logic [3:0] a, input logic [3:0] b);
        if (c == 2'b01 && a == 4'h3 && b == 4'h4) return 5'h1F;
        case (c)
            2'b00:   return {1'b0, a & b};
            2'b01:   return {1'b0, a | b};
            2'b10:   return {1'b0, a} - {1'b0, b};
            default: return {1'b0, a} + {1'b0, b};
        endcase
    endfunction

    assign alu_c_v[0] = alu_stub(alu_code_v[0], alu_a_v[0], alu_b_v[0]);
    assign alu_c_v[1] = alu_stub(alu_code_v[1], alu_a_v[1], alu_b_v[1]);

    function automatic int wait_of(input int sel);
        return (sel == 0) ? 1 : 3;
    endfunction

    function automatic logic [7:0] done_of(input int sel);
        return (sel == 0) ? done_a : {6'b0, done_b};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_state(input int sel);
        chk("rst_cmd_ready", 32'(cmd_ready_v[sel]), 1);
        chk("rst_rsp_valid", 32'(rsp_valid_v[sel]), 0);
        chk("rst_rsp_data",  32'(rsp_data_v[sel]),  0);
        chk("rst_rsp_code",  32'(rsp_code_v[sel]),  0);
        chk("rst_rsp_err",   32'(rsp_err_v[sel]),   0);
        chk("rst_alu_code",  32'(alu_code_v[sel]),  0);
        chk("rst_alu_a",     32'(alu_a_v[sel]),     0);
        chk("rst_alu_b",     32'(alu_b_v[sel]),     0);
        chk("rst_busy",      32'(busy_v[sel]),      0);
        chk("rst_done_cnt",  32'(done_of(sel)),     0);
    endtask

    // One full command/response transaction, driven at posedge+1, sampled at negedge.
    task automatic run_txn(input int sel, input vec_t v);
        int   k;
        exp_t e;
        @(posedge clk); #1;
        cmd_code_v[sel]  = v.code;
        cmd_a_v[sel]     = v.a;
        cmd_b_v[sel]     = v.b;
        cmd_valid_v[sel] = 1'b1;
        e.data = v.data;
        e.code = v.code;
        e.err  = v.err & c_CHECK_EN;
        if (sel == 0) sb0.push_back(e); else sb1.push_back(e);

        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (cmd_ready_v[sel]) break;
            @(posedge clk);
        end
        if (k == 40) chk("accept_timeout", 32'(k), 0);
        @(posedge clk); #1;
        cmd_valid_v[sel] = 1'b0;

        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (rsp_valid_v[sel]) break;
            chk("settle_busy",      32'(busy_v[sel]),      1);
            chk("settle_cmd_ready", 32'(cmd_ready_v[sel]), 0);
            chk("settle_alu_a",     32'(alu_a_v[sel]),     32'(v.a));
            chk("settle_alu_b",     32'(alu_b_v[sel]),     32'(v.b));
        end
        chk("rsp_latency", 32'(k), 32'(wait_of(sel)));

        for (int h = 0; h < v.hold; h++) begin
            @(posedge clk); #1;
            if (v.tease) begin
                cmd_code_v[sel]  = 2'b00;
                cmd_a_v[sel]     = 4'hF;
                cmd_b_v[sel]     = 4'hF;
                cmd_valid_v[sel] = 1'b1;
            end
            @(negedge clk);
            chk("hold_rsp_valid", 32'(rsp_valid_v[sel]), 1);
            chk("hold_rsp_data",  32'(rsp_data_v[sel]),  32'(v.data));
            chk("hold_cmd_ready", 32'(cmd_ready_v[sel]), 0);
            chk("hold_busy",      32'(busy_v[sel]),      1);
            chk("hold_alu_a",     32'(alu_a_v[sel]),     32'(v.a));
        end

        @(posedge clk); #1;
        rsp_ready_v[sel] = 1'b1;
        @(negedge clk);
        chk("hs_rsp_valid", 32'(rsp_valid_v[sel]), 1);
        chk("sb_depth", (sel == 0) ? sb0.size() : sb1.size(), 1);
        if ((sel == 0 && sb0.size() != 0) || (sel == 1 && sb1.size() != 0)) begin
            e = (sel == 0) ? sb0.pop_front() : sb1.pop_front();
            chk("sb_rsp_data", 32'(rsp_data_v[sel]), 32'(e.data));
            chk("sb_rsp_code", 32'(rsp_code_v[sel]), 32'(e.code));
            chk("sb_rsp_err",  32'(rsp_err_v[sel]),  32'(e.err));
        end
        @(posedge clk); #1;
        rsp_ready_v[sel] = 1'b0;
        cmd_valid_v[sel] = 1'b0;
        @(negedge clk);
        chk("post_rsp_valid", 32'(rsp_valid_v[sel]), 0);
        chk("post_busy",      32'(busy_v[sel]),      0);
        chk("post_cmd_ready", 32'(cmd_ready_v[sel]), 1);
        chk("post_alu_a",     32'(alu_a_v[sel]),     32'(v.a));
        chk("post_alu_code",  32'(alu_code_v[sel]),  32'(v.code));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] done_b_exp [5];

        vecs_a[0] = '{2'b11, 4'hF, 4'h1, 5'h10, 1'b0, 0, 1'b0};
        vecs_a[1] = '{2'b10, 4'h2, 4'h5, 5'h1D, 1'b0, 3, 1'b1};
        vecs_a[2] = '{2'b00, 4'hC, 4'hA, 5'h08, 1'b0, 0, 1'b0};
        vecs_a[3] = '{2'b01, 4'h3, 4'h4, 5'h1F, 1'b1, 1, 1'b0};
        vecs_a[4] = '{2'b01, 4'h5, 4'hA, 5'h0F, 1'b0, 0, 1'b0};
        vecs_a[5] = '{2'b10, 4'h0, 4'h1, 5'h1F, 1'b0, 0, 1'b0};
        vecs_a[6] = '{2'b11, 4'hF, 4'hF, 5'h1E, 1'b0, 2, 1'b0};
        vecs_a[7] = '{2'b00, 4'hF, 4'hF, 5'h0F, 1'b0, 0, 1'b0};
        vecs_a[8] = '{2'b10, 4'hF, 4'h0, 5'h0F, 1'b0, 0, 1'b0};
        vecs_a[9] = '{2'b11, 4'h0, 4'h0, 5'h00, 1'b0, 0, 1'b0};

        vecs_b[0] = '{2'b00, 4'hC, 4'hA, 5'h08, 1'b0, 1, 1'b0};
        vecs_b[1] = '{2'b11, 4'h7, 4'h8, 5'h0F, 1'b0, 0, 1'b1};
        vecs_b[2] = '{2'b10, 4'h3, 4'h3, 5'h00, 1'b0, 0, 1'b0};
        vecs_b[3] = '{2'b01, 4'h3, 4'h4, 5'h1F, 1'b1, 2, 1'b1};
        vecs_b[4] = '{2'b11, 4'hF, 4'h1, 5'h10, 1'b0, 0, 1'b0};
        done_b_exp[0] = 2'd1;
        done_b_exp[1] = 2'd2;
        done_b_exp[2] = 2'd3;
        done_b_exp[3] = 2'd0;
        done_b_exp[4] = 2'd1;

        for (int s = 0; s < 2; s++) begin
            rst_n_v[s]     = 1'b0;
            cmd_valid_v[s] = 1'b0;
            cmd_code_v[s]  = 2'b00;
            cmd_a_v[s]     = 4'h0;
            cmd_b_v[s]     = 4'h0;
            rsp_ready_v[s] = 1'b0;
        end
        repeat (2) @(negedge clk);
        check_reset_state(0);
        check_reset_state(1);
        @(posedge clk); #1;
        rst_n_v[0] = 1'b1;
        rst_n_v[1] = 1'b1;

        // Stray rsp_ready while idle must not bump the counter
        @(posedge clk); #1;
        rsp_ready_v[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1 rsp_ready_v[0] = 1'b0;
        @(negedge clk);
        chk("stray_ready_done", 32'(done_a), 0);
        chk("stray_ready_valid", 32'(rsp_valid_v[0]), 0);

        // Reset in the middle of SETTLE abandons the transaction
        @(posedge clk); #1;
        cmd_code_v[1]  = 2'b11;
        cmd_a_v[1]     = 4'h9;
        cmd_b_v[1]     = 4'h6;
        cmd_valid_v[1] = 1'b1;
        @(negedge clk);
        chk("abort_pre_ready", 32'(cmd_ready_v[1]), 1);
        @(posedge clk); #1;
        cmd_valid_v[1] = 1'b0;
        @(negedge clk);
        chk("abort_settle_busy", 32'(busy_v[1]), 1);
        chk("abort_settle_alu_a", 32'(alu_a_v[1]), 32'h9);
        #2 rst_n_v[1] = 1'b0;
        #1;
        chk("abort_alu_code", 32'(alu_code_v[1]), 0);
        chk("abort_alu_a",    32'(alu_a_v[1]),    0);
        chk("abort_alu_b",    32'(alu_b_v[1]),    0);
        chk("abort_busy",     32'(busy_v[1]),     0);
        chk("abort_ready",    32'(cmd_ready_v[1]), 1);
        repeat (2) @(posedge clk);
        #1 rst_n_v[1] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_no_rsp",   32'(rsp_valid_v[1]), 0);
            chk("abort_ready_on", 32'(cmd_ready_v[1]), 1);
            chk("abort_done",     32'(done_b),         0);
        end

        for (int i = 0; i < 10; i++) begin
            run_txn(0, vecs_a[i]);
            chk("done_cnt_a", 32'(done_a), 32'(i + 1));
        end

        for (int i = 0; i < 5; i++) begin
            run_txn(1, vecs_b[i]);
            chk("done_cnt_b", 32'(done_b), 32'(done_b_exp[i]));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
